// File: rtl/cfg_word_serializer_if.sv
// Handshake and serial-bus bundle between the config controller side and the word serializer.
interface cfg_word_serializer_if #(
  parameter int WORD_W = 24
);
  logic              cs_i;
  logic [3:0]        inst_i;
  logic              waddr_clr;
  logic [WORD_W-1:0] rom_data;
  logic [7:0]        rom_addr;
  logic [3:0]        waddr;
  logic              busy;
  logic              word_done;
  logic              spi_cs_n;
  logic              spi_sclk;
  logic              spi_mosi;

  modport master (
    output cs_i, inst_i, waddr_clr, rom_data,
    input  rom_addr, waddr, busy, word_done, spi_cs_n, spi_sclk, spi_mosi
  );

  modport slave (
    input  cs_i, inst_i, waddr_clr, rom_data,
    output rom_addr, waddr, busy, word_done, spi_cs_n, spi_sclk, spi_mosi
  );
endinterface

// File: rtl/cfg_word_serializer.sv
// Fetches the current instruction's config words from ROM and shifts each one MSB-first
// onto the 3-wire serial bus while the controller holds cs_i in its write state.
module cfg_word_serializer #(
  parameter int WORD_W    = 24,
  parameter int NUM_WORDS = 8,
  parameter int SCLK_DIV  = 2,
  parameter int GAP_CYC   = 4
) (
  input logic                  clk,
  input logic                  rst,
  cfg_word_serializer_if.slave bus
);
  localparam int BW = $clog2(WORD_W + 1);
  localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;
  state_t state, state_nxt;

  logic [WORD_W-1:0] shreg;
  logic [BW-1:0]     bit_cnt;
  logic [DW-1:0]     div_cnt;
  logic [GW-1:0]     gap_cnt;
  logic              pend_clr;
  logic [3:0]        waddr;
  logic [7:0]        rom_addr;
  logic              cs_n, sclk, mosi;
  logic              busy, word_done;
  logic              div_last, bit_last, gap_last, clr_now, start;

  assign div_last = div_cnt == DW'(SCLK_DIV - 1);
  assign bit_last = bit_cnt == BW'(WORD_W - 1);
  assign gap_last = gap_cnt == GW'(GAP_CYC - 1);
  assign clr_now  = pend_clr | bus.waddr_clr;
  assign start    = bus.cs_i && (waddr < 4'(NUM_WORDS));

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    word_done = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        // A clear always takes its own idle cycle, so it wins over a simultaneous start.
        if (!clr_now && start) state_nxt = LOAD;
      end
      LOAD:  state_nxt = SHIFT;
      SHIFT: if (div_last && sclk && bit_last) state_nxt = GAP;
      GAP: begin
        if (gap_last) begin
          word_done = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      waddr    <= '0;
      rom_addr <= '0;
      shreg    <= '0;
      bit_cnt  <= '0;
      div_cnt  <= '0;
      gap_cnt  <= '0;
      pend_clr <= 1'b0;
      cs_n     <= 1'b1;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state != IDLE && bus.waddr_clr) pend_clr <= 1'b1;
      case (state)
        IDLE: begin
          if (clr_now) begin
            waddr    <= '0;
            pend_clr <= 1'b0;
          end else if (start) begin
            rom_addr <= {bus.inst_i, waddr};
          end
        end
        LOAD: begin
          shreg   <= bus.rom_data;
          mosi    <= bus.rom_data[WORD_W-1];
          cs_n    <= 1'b0;
          div_cnt <= '0;
          bit_cnt <= '0;
        end
        SHIFT: begin
          div_cnt <= div_last ? '0 : div_cnt + 1'b1;
          if (div_last) begin
            sclk <= ~sclk;
            // Falling edge: advance to the next bit, or close the frame after the last one.
            if (sclk) begin
              if (bit_last) begin
                cs_n    <= 1'b1;
                mosi    <= 1'b0;
                gap_cnt <= '0;
              end else begin
                shreg   <= shreg << 1;
                mosi    <= shreg[WORD_W-2];
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt + 1'b1;
          if (gap_last && waddr < 4'(NUM_WORDS)) waddr <= waddr + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.rom_addr  = rom_addr;
  assign bus.waddr     = waddr;
  assign bus.busy      = busy;
  assign bus.word_done = word_done;
  assign bus.spi_cs_n  = cs_n;
  assign bus.spi_sclk  = sclk;
  assign bus.spi_mosi  = mosi;
endmodule

// File: tb/tb_cfg_word_serializer.sv
// Directed bench: serial frames are reassembled from the bus and compared with a ROM model.
module tb_cfg_word_serializer;
  localparam int SHIFT1 = 24 * 2 * 2;     // default SCLK_DIV=2
  localparam int HIGH1  = 4 + 2;          // GAP + idle decision + LOAD between frames
  localparam int SHIFT2 = 24 * 2 * 1;     // SCLK_DIV=1
  localparam int PER2   = SHIFT2 + 1 + 2; // frame-to-frame with GAP_CYC=1

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cfg_word_serializer_if #(.WORD_W(24)) bus1();
  cfg_word_serializer_if #(.WORD_W(24)) bus2();

  cfg_word_serializer #(.WORD_W(24), .NUM_WORDS(8), .SCLK_DIV(2), .GAP_CYC(4))
    dut (.clk(clk), .rst(rst), .bus(bus1));
  cfg_word_serializer #(.WORD_W(24), .NUM_WORDS(8), .SCLK_DIV(1), .GAP_CYC(1))
    dut2 (.clk(clk), .rst(rst), .bus(bus2));

  function automatic logic [23:0] rom_val(input logic [7:0] a);
    if (a == 8'h30) return 24'hA50F3C;
    return {a, ~a, a ^ 8'h5A};
  endfunction

  assign bus1.rom_data = rom_val(bus1.rom_addr);
  assign bus2.rom_data = rom_val(bus2.rom_addr);

  typedef struct {
    logic [7:0]  addr;
    logic [23:0] word;
    int          nbits;
    int          t0;
    int          t1;
  } frame_t;
  frame_t fq[$];

  typedef struct {
    logic [3:0]  inst;
    logic [7:0]  exp_addr;
    logic [23:0] exp_word;
  } vec_t;

  int tests = 0;
  int fails = 0;

  // Frame monitor for dut: samples on the falling clk edge.
  int cyc = 0;
  logic [23:0] cur_word = '0;
  int cur_nbits = 0;
  logic [7:0] cur_addr = '0;
  int cur_t0 = 0;
  initial begin
    logic pcs, psclk;
    frame_t f;
    pcs = 1'b1;
    psclk = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (pcs && !bus1.spi_cs_n) begin
        cur_word = '0; cur_nbits = 0; cur_addr = bus1.rom_addr; cur_t0 = cyc;
      end
      if (!bus1.spi_cs_n && bus1.spi_sclk && !psclk) begin
        cur_word = {cur_word[22:0], bus1.spi_mosi};
        cur_nbits++;
      end
      if (!pcs && bus1.spi_cs_n) begin
        f.addr = cur_addr; f.word = cur_word; f.nbits = cur_nbits;
        f.t0 = cur_t0; f.t1 = cyc;
        fq.push_back(f);
      end
      pcs = bus1.spi_cs_n;
      psclk = bus1.spi_sclk;
    end
  end

  int s2[$];
  int e2[$];
  initial begin
    int c2;
    logic p2;
    c2 = 0;
    p2 = 1'b1;
    forever begin
      @(negedge clk);
      c2++;
      if (p2 && !bus2.spi_cs_n) s2.push_back(c2);
      if (!p2 && bus2.spi_cs_n) e2.push_back(c2);
      p2 = bus2.spi_cs_n;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clr_pulse();
    bus1.waddr_clr = 1'b1;
    tick();
    bus1.waddr_clr = 1'b0;
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[4];
    vt[0] = '{inst: 4'h3, exp_addr: 8'h30, exp_word: 24'hA50F3C};
    vt[1] = '{inst: 4'h5, exp_addr: 8'h50, exp_word: 24'h50AF0A};
    vt[2] = '{inst: 4'hF, exp_addr: 8'hF0, exp_word: 24'hF00FAA};
    vt[3] = '{inst: 4'h0, exp_addr: 8'h00, exp_word: 24'h00FF5A};

    bus1.cs_i = 1'b0; bus1.inst_i = '0; bus1.waddr_clr = 1'b0;
    bus2.cs_i = 1'b0; bus2.inst_i = '0; bus2.waddr_clr = 1'b0;
    repeat (3) tick();
    chk("rst_cs_n", bus1.spi_cs_n, 1);
    chk("rst_sclk", bus1.spi_sclk, 0);
    chk("rst_mosi", bus1.spi_mosi, 0);
    chk("rst_waddr", bus1.waddr, 0);
    chk("rst_rom_addr", bus1.rom_addr, 0);
    chk("rst_busy", bus1.busy, 0);
    chk("rst_word_done", bus1.word_done, 0);
    rst = 1'b0;
    tick();

    // Single-word transactions from the vector table.
    for (int v = 0; v < 4; v++) begin
      clr_pulse();
      fq.delete();
      bus1.inst_i = vt[v].inst;
      bus1.cs_i = 1'b1;
      tick();
      chk("load_cs_n", bus1.spi_cs_n, 1);
      chk("load_busy", bus1.busy, 1);
      bus1.cs_i = 1'b0;
      tick();
      chk("latency_cs_n", bus1.spi_cs_n, 0);
      for (int i = 0; i < 300 && !bus1.word_done; i++) tick();
      chk("word_done_seen", bus1.word_done, 1);
      tick();
      chk("word_done_pulse", bus1.word_done, 0);
      chk("vec_waddr", bus1.waddr, 1);
      chk("vec_idle", bus1.busy, 0);
      chk("vec_frames", fq.size(), 1);
      if (fq.size() > 0) begin
        chk("vec_addr", fq[0].addr, vt[v].exp_addr);
        chk("vec_word", fq[0].word, vt[v].exp_word);
        chk("vec_nbits", fq[0].nbits, 24);
        chk("vec_shift_len", fq[0].t1 - fq[0].t0, SHIFT1);
      end
    end

    // Full instruction: exactly NUM_WORDS frames, then saturation.
    clr_pulse();
    fq.delete();
    bus1.inst_i = 4'h3;
    bus1.cs_i = 1'b1;
    for (int i = 0; i < 1500 && !(bus1.waddr == 8 && !bus1.busy); i++) tick();
    chk("full_waddr", bus1.waddr, 8);
    repeat (300) tick();
    chk("full_no_9th", fq.size(), 8);
    chk("full_sat_waddr", bus1.waddr, 8);
    chk("full_sat_idle", bus1.busy, 0);
    for (int k = 0; k < 8 && k < fq.size(); k++) begin
      chk("full_addr", fq[k].addr, 8'h30 + 8'(k));
      chk("full_word", fq[k].word, rom_val(8'h30 + 8'(k)));
      if (k > 0) chk("full_gap", fq[k].t0 - fq[k-1].t1, HIGH1);
    end
    bus1.cs_i = 1'b0;
    tick();

    // cs_i dropped mid-word 2: word completes, nothing follows.
    clr_pulse();
    fq.delete();
    bus1.cs_i = 1'b1;
    for (int i = 0; i < 1000 && !(bus1.waddr == 2 && !bus1.spi_cs_n && cur_nbits == 10); i++)
      tick();
    chk("drop_reached", cur_nbits, 10);
    bus1.cs_i = 1'b0;
    for (int i = 0; i < 400 && !(bus1.waddr == 3 && !bus1.busy); i++) tick();
    repeat (150) tick();
    chk("drop_waddr", bus1.waddr, 3);
    chk("drop_frames", fq.size(), 3);
    if (fq.size() == 3) begin
      chk("drop_nbits", fq[2].nbits, 24);
      chk("drop_word", fq[2].word, rom_val(8'h32));
    end

    // waddr_clr during word 5: word finishes, then index restarts at 0.
    fq.delete();
    bus1.cs_i = 1'b1;
    for (int i = 0; i < 1000 && !(bus1.waddr == 5 && !bus1.spi_cs_n && cur_nbits >= 4); i++)
      tick();
    chk("clr_reached", bus1.waddr, 5);
    bus1.waddr_clr = 1'b1;
    tick();
    bus1.waddr_clr = 1'b0;
    chk("clr_busy", bus1.busy, 1);
    for (int i = 0; i < 400 && !bus1.word_done; i++) tick();
    chk("clr_done", bus1.word_done, 1);
    tick();
    chk("clr_waddr6", bus1.waddr, 6);
    tick();
    chk("clr_waddr0", bus1.waddr, 0);
    for (int i = 0; i < 20 && bus1.spi_cs_n; i++) tick();
    chk("clr_restart", bus1.spi_cs_n, 0);
    chk("clr_rom_addr", bus1.rom_addr, 8'h30);
    bus1.cs_i = 1'b0;
    for (int i = 0; i < 300 && bus1.busy; i++) tick();
    chk("clr_frames", fq.size(), 4);
    if (fq.size() == 4) begin
      chk("clr_w5_nbits", fq[2].nbits, 24);
      chk("clr_w5_word", fq[2].word, rom_val(8'h35));
      chk("clr_new_addr", fq[3].addr, 8'h30);
    end

    // Reset in the middle of a word.
    fq.delete();
    bus1.cs_i = 1'b1;
    for (int i = 0; i < 400 && !(!bus1.spi_cs_n && cur_nbits == 12); i++) tick();
    chk("rst_mid_reached", cur_nbits, 12);
    rst = 1'b1;
    #1;
    chk("rst_mid_cs_n", bus1.spi_cs_n, 1);
    chk("rst_mid_sclk", bus1.spi_sclk, 0);
    chk("rst_mid_mosi", bus1.spi_mosi, 0);
    chk("rst_mid_waddr", bus1.waddr, 0);
    chk("rst_mid_busy", bus1.busy, 0);
    tick();
    rst = 1'b0;
    fq.delete();
    for (int i = 0; i < 300 && !bus1.word_done; i++) tick();
    chk("rst_restart_done", bus1.word_done, 1);
    bus1.cs_i = 1'b0;
    tick();
    chk("rst_restart_frames", fq.size(), 1);
    if (fq.size() > 0) begin
      chk("rst_restart_addr", fq[0].addr, 8'h30);
      chk("rst_restart_word", fq[0].word, 24'hA50F3C);
      chk("rst_restart_nbits", fq[0].nbits, 24);
    end

    // Fastest timing instance: back-to-back frame spacing.
    s2.delete();
    e2.delete();
    bus2.inst_i = 4'h3;
    bus2.cs_i = 1'b1;
    for (int i = 0; i < 400 && s2.size() < 3; i++) tick();
    bus2.cs_i = 1'b0;
    for (int i = 0; i < 200 && bus2.busy; i++) tick();
    chk("fast_frames", s2.size(), 3);
    if (s2.size() >= 3 && e2.size() >= 1) begin
      chk("fast_shift_len", e2[0] - s2[0], SHIFT2);
      chk("fast_period1", s2[1] - s2[0], PER2);
      chk("fast_period2", s2[2] - s2[1], PER2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
